// File: rtl/id_stage_reg.sv
// Instruction-decode stage with register file, condition check, RAW hazard
// detection and the ID/EX pipeline register feeding EX.
module id_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_NUM = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       instruction,
    input  logic [3:0]        sr,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic [3:0]        exe_dest,
    input  logic              mem_wb_en,
    input  logic [3:0]        mem_dest,
    output logic              hazard,
    output logic [31:0]       pc_out,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic [3:0]        exe_cmd,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en_out,
    output logic              b,
    output logic              s
);

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_NONE = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
        OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       b;
        logic       s;
    } ctrl_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
        ctrl_t             ctrl;
    } idex_t;

    logic [3:0] cond_f, opcode_f, rn_f, rd_f, rm_f, src2_sel;
    logic       i_bit, sl_bit;
    mode_e      mode_f;

    assign cond_f   = instruction[31:28];
    assign mode_f   = mode_e'(instruction[27:26]);
    assign i_bit    = instruction[25];
    assign opcode_f = instruction[24:21];
    assign sl_bit   = instruction[20];
    assign rn_f     = instruction[19:16];
    assign rd_f     = instruction[15:12];
    assign rm_f     = instruction[3:0];

    logic [DATA_W-1:0] rf_q [REG_NUM];
    logic [DATA_W-1:0] rf_d [REG_NUM];
    idex_t             idex_q, idex_d;
    ctrl_t             ctrl_dec, ctrl_eff;
    logic              cond_ok, uses_rn, two_src;
    logic [DATA_W-1:0] rd_rn, rd_rm;

    always_comb begin
        ctrl_dec = '0;
        case (mode_f)
            MODE_DP: begin
                ctrl_dec.wb_en = 1'b1;
                ctrl_dec.s     = sl_bit;
                case (opcode_e'(opcode_f))
                    OP_MOV: ctrl_dec.exe_cmd = 4'b0001;
                    OP_MVN: ctrl_dec.exe_cmd = 4'b1001;
                    OP_ADD: ctrl_dec.exe_cmd = 4'b0010;
                    OP_ADC: ctrl_dec.exe_cmd = 4'b0011;
                    OP_SUB: ctrl_dec.exe_cmd = 4'b0100;
                    OP_SBC: ctrl_dec.exe_cmd = 4'b0101;
                    OP_AND: ctrl_dec.exe_cmd = 4'b0110;
                    OP_ORR: ctrl_dec.exe_cmd = 4'b0111;
                    OP_EOR: ctrl_dec.exe_cmd = 4'b1000;
                    OP_CMP: begin
                        ctrl_dec.exe_cmd = 4'b0100;
                        ctrl_dec.wb_en   = 1'b0;
                        ctrl_dec.s       = 1'b1;
                    end
                    OP_TST: begin
                        ctrl_dec.exe_cmd = 4'b0110;
                        ctrl_dec.wb_en   = 1'b0;
                        ctrl_dec.s       = 1'b1;
                    end
                    default: ctrl_dec = '0;
                endcase
            end
            MODE_MEM: begin
                ctrl_dec.exe_cmd  = 4'b0010;
                ctrl_dec.mem_r_en = sl_bit;
                ctrl_dec.wb_en    = sl_bit;
                ctrl_dec.mem_w_en = ~sl_bit;
            end
            MODE_BR: ctrl_dec.b = 1'b1;
            default: ctrl_dec = '0;
        endcase
    end

    // sr = {N,Z,C,V}
    always_comb begin
        case (cond_f)
            4'b0000: cond_ok = sr[2];
            4'b0001: cond_ok = ~sr[2];
            4'b0010: cond_ok = sr[1];
            4'b0011: cond_ok = ~sr[1];
            4'b0100: cond_ok = sr[3];
            4'b0101: cond_ok = ~sr[3];
            4'b0110: cond_ok = sr[0];
            4'b0111: cond_ok = ~sr[0];
            4'b1000: cond_ok = sr[1] & ~sr[2];
            4'b1001: cond_ok = ~sr[1] | sr[2];
            4'b1010: cond_ok = (sr[3] == sr[0]);
            4'b1011: cond_ok = (sr[3] != sr[0]);
            4'b1100: cond_ok = ~sr[2] & (sr[3] == sr[0]);
            4'b1101: cond_ok = sr[2] | (sr[3] != sr[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign ctrl_eff = cond_ok ? ctrl_dec : '0;
    assign src2_sel = ctrl_dec.mem_w_en ? rd_f : rm_f;
    assign uses_rn  = (mode_f == MODE_DP && opcode_f != OP_MOV && opcode_f != OP_MVN)
                   || (mode_f == MODE_MEM);
    assign two_src  = (mode_f == MODE_DP && !i_bit) || ctrl_dec.mem_w_en;

    function automatic logic in_flight(input logic [3:0] x, input logic e_en,
                                       input logic [3:0] e_d, input logic m_en,
                                       input logic [3:0] m_d);
        return (e_en && x == e_d) || (m_en && x == m_d);
    endfunction

    assign hazard = !ctrl_dec.b &&
                    ((uses_rn && in_flight(rn_f, exe_wb_en, exe_dest, mem_wb_en, mem_dest)) ||
                     (two_src && in_flight(src2_sel, exe_wb_en, exe_dest, mem_wb_en, mem_dest)));

    // Index 15 matches no entry, so it reads 0 and is never bypassed.
    always_comb begin
        rd_rn = '0;
        rd_rm = '0;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            rf_d[i] = rf_q[i];
            if (wb_en && wb_dest == 4'(i)) rf_d[i] = wb_value;
            if (rn_f == 4'(i)) rd_rn = rf_d[i];
            if (src2_sel == 4'(i)) rd_rm = rf_d[i];
        end
    end

    always_comb begin
        idex_d = '0;
        if (!flush) begin
            idex_d.pc            = pc_in;
            idex_d.val_rn        = rd_rn;
            idex_d.val_rm        = rd_rm;
            idex_d.imm           = i_bit;
            idex_d.shift_operand = instruction[11:0];
            idex_d.signed_imm_24 = instruction[23:0];
            idex_d.dest          = rd_f;
            idex_d.src1          = rn_f;
            idex_d.src2          = src2_sel;
            idex_d.ctrl          = hazard ? '0 : ctrl_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
            for (int unsigned i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
        end else begin
            idex_q <= idex_d;
            rf_q   <= rf_d;
        end
    end

    assign pc_out        = idex_q.pc;
    assign val_rn        = idex_q.val_rn;
    assign val_rm        = idex_q.val_rm;
    assign imm           = idex_q.imm;
    assign shift_operand = idex_q.shift_operand;
    assign signed_imm_24 = idex_q.signed_imm_24;
    assign dest          = idex_q.dest;
    assign src1          = idex_q.src1;
    assign src2          = idex_q.src2;
    assign exe_cmd       = idex_q.ctrl.exe_cmd;
    assign mem_r_en      = idex_q.ctrl.mem_r_en;
    assign mem_w_en      = idex_q.ctrl.mem_w_en;
    assign wb_en_out     = idex_q.ctrl.wb_en;
    assign b             = idex_q.ctrl.b;
    assign s             = idex_q.ctrl.s;

endmodule

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- Instruction-decode stage of the 5-stage ARM-subset pipeline, plus the ID/EX pipeline register.
- Consumes the fetch stage's registered instruction and PC+4, which come from the IF/ID register.
- Contains:
  - 15-entry register file, written from WB
  - control decoder
  - condition-code check
  - RAW hazard detector; its hazard output freezes fetch and IF/ID
- Registered outputs feed the EX stage.

Parameters:
- DATA_W, 32, datapath and register width
- REG_NUM, 15, architectural registers R0..R14; index 15 is never written and reads 0

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- flush  in  1  branch taken in EX; kill the instruction currently in ID
- pc_in  in  32  PC+4 of the instruction in ID
- instruction  in  32  instruction in ID
- sr  in  4  status flags {N,Z,C,V} from the status register
- wb_en  in  1  writeback enable from WB
- wb_dest  in  4  writeback register index
- wb_value  in  32  writeback data
- exe_wb_en  in  1  wb_en of the instruction in EX
- exe_dest  in  4  dest of the instruction in EX
- mem_wb_en  in  1  wb_en of the instruction in MEM
- mem_dest  in  4  dest of the instruction in MEM
- hazard  out  1  combinational; freeze request to fetch and IF/ID
- pc_out  out  32  registered pc_in
- val_rn  out  32  registered Rn value
- val_rm  out  32  registered value of source 2 (Rm, or Rd for STR)
- imm  out  1  registered I bit
- shift_operand  out  12  registered instruction[11:0]
- signed_imm_24  out  24  registered instruction[23:0]
- dest  out  4  registered Rd
- src1, src2  out  4 each  registered source indices, for EX forwarding
- exe_cmd  out  4  registered ALU command
- mem_r_en, mem_w_en, wb_en_out, b, s  out  1 each  registered controls

Behaviour:
- Field map:
  - cond = [31:28]
  - mode = [27:26]
  - I = [25]
  - opcode = [24:21]
  - S/L = [20]
  - Rn = [19:16]
  - Rd = [15:12]
  - Rm = [3:0]
- Decode for mode 00 (data processing); wb_en = 1 except CMP and TST; s = S bit, forced 1 for CMP and TST:

  | Mnemonic | opcode | exe_cmd |
  |---|---|---|
  | MOV | 1101 | 0001 |
  | MVN | 1111 | 1001 |
  | ADD | 0100 | 0010 |
  | ADC | 0101 | 0011 |
  | SUB | 0010 | 0100 |
  | SBC | 0110 | 0101 |
  | AND | 0000 | 0110 |
  | ORR | 1100 | 0111 |
  | EOR | 0001 | 1000 |
  | CMP | 1010 | 0100 |
  | TST | 1000 | 0110 |

  Any other opcode gives all controls 0.
- Mode 01 (memory):
  - exe_cmd = 0010
  - L = 1 (LDR): mem_r_en = 1, wb_en = 1
  - L = 0 (STR): mem_w_en = 1
  - s = 0
- Mode 10 (branch): b = 1, all other controls 0.
- Mode 11: all controls 0.
- Condition check: evaluate cond against sr using the standard ARM table (EQ..LE, AL = 1110, 1111 = never). On failure, all controls are forced to 0; data fields still propagate.
- Sources:
  - src1 = Rn
  - src2 = Rd if mem_w_en, else Rm
- Operand use:
  - uses_rn = mode 00 except MOV/MVN, or mode 01
  - two_src = (mode 00 and I = 0) or STR
- hazard = !b_dec && ((uses_rn && match(src1)) || (two_src && match(src2))), where match(x) = (exe_wb_en && x == exe_dest) || (mem_wb_en && x == mem_dest).
- hazard is combinational, with no latency.
- Register file:
  - Write on posedge when wb_en and wb_dest != 15.
  - Reads are combinational.
  - Same-cycle write/read of the same index returns wb_value (bypass).
- ID/EX register, priority rst > flush > hazard > normal:
  - rst: every registered output = 0. All 15 registers cleared to 0 on the same edge.
  - flush: all registered outputs = 0, so a bubble enters EX. The register file still accepts the WB write.
  - hazard: controls (exe_cmd, mem_r_en, mem_w_en, wb_en_out, b, s) = 0; other fields load normally.
  - normal: load the decoded values; latency from ID to EX outputs is 1 cycle.
- Reset mid-operation clears the pipeline register and the register file on the same edge. There is no partial state.

Test Plan:
- Reset then MOV R0,#20 (0xE3A00014) with sr = 0 → after 1 clk: exe_cmd = 0001, wb_en_out = 1, dest = 0, imm = 1, shift_operand = 0x014, hazard = 0.
- Register-file bypass: wb_en = 1, wb_dest = 2, wb_value = 0xC0000000 while decoding ADDS R3,R2,R2 (0xE0923002) → val_rn = val_rm = 0xC0000000, s = 1.
- Hazard: ADC R4,R0,R0 with exe_wb_en = 1, exe_dest = 0 → hazard = 1 and the next ID/EX controls are 0. Dropping exe_wb_en gives hazard = 0 and exe_cmd = 0011.
- Conditional execution: ADDNE R1,R1,R1 (0x10811001):
  - sr Z = 1 → all controls 0
  - sr Z = 0 → exe_cmd = 0010, wb_en_out = 1
- STR R1,[R0],#0 (0xE4801000) with mem_dest = 1, mem_wb_en = 1 → src2 = 1, hazard = 1. Then LDR R11 (0xE490B000) → mem_r_en = 1, wb_en_out = 1, dest = 11.
- Priority: flush = 1 and hazard = 1 in the same cycle → all outputs 0. Write to wb_dest = 15 → a subsequent read of index 15 returns 0.
